// File: rtl/slave_if.sv
// -----------------------------------------------------------------------------
// slave_if
//
// Slave-side end of the crossbar request/ack protocol. The block accepts one
// transaction from the crossbar and registers it. It then presents that
// transaction to the attached slave and holds it stable until the slave acks.
// Finally it returns a one-cycle ack to the crossbar, carrying the requesting
// master's ID, the read data and an error flag.
//
// A timeout counter turns a slave that never acks into an error response, so
// crossbar arbitration can never lock up behind a hung slave.
//
// Parameters
//   ADDR_W   address width
//   DATA_W   data width
//   ID_W     master ID width
//   TIMEOUT  max REQ cycles waiting for a slave ack; 0 disables the timeout
//
// Ports
//   clk, rst_n             clock (rising edge), asynchronous active-low reset
//   *_from_crossbar        incoming transaction: req, addr, wdata, cmd, id
//   ack/rdata/id/err_to_crossbar
//                          completion pulse and response (valid only in RESP)
//   req/addr/wdata/cmd_to_slave
//                          registered transaction toward the slave (REQ only)
//   ack_from_slave, rdata_from_slave
//                          slave completion and read data
//   busy                   high whenever the FSM is not in IDLE
// -----------------------------------------------------------------------------
module slave_if #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned ID_W    = 2,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,

  input  logic              req_from_crossbar,
  input  logic [ADDR_W-1:0] addr_from_crossbar,
  input  logic [DATA_W-1:0] wdata_from_crossbar,
  input  logic              cmd_from_crossbar,
  input  logic [ID_W-1:0]   id_from_crossbar,

  output logic              ack_to_crossbar,
  output logic [DATA_W-1:0] rdata_to_crossbar,
  output logic [ID_W-1:0]   id_to_crossbar,
  output logic              err_to_crossbar,

  output logic              req_to_slave,
  output logic [ADDR_W-1:0] addr_to_slave,
  output logic [DATA_W-1:0] wdata_to_slave,
  output logic              cmd_to_slave,
  input  logic              ack_from_slave,
  input  logic [DATA_W-1:0] rdata_from_slave,

  output logic              busy
);

  // Counter width holds the value TIMEOUT. It is at least one bit, so the
  // timeout-disabled build still elaborates.
  localparam int unsigned CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

  // Counter value in the last REQ cycle before a timeout fires. It is unused
  // when TIMEOUT is 0.
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT == 0) ? '0 : CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              cmd_q;
  logic [ID_W-1:0]   id_q;
  logic [DATA_W-1:0] rdata_q;
  logic              err_q;
  logic [CNT_W-1:0]  cnt_q;

  // Timeout fires in the TIMEOUT-th REQ cycle that has no ack.
  logic timeout_hit;
  assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CNT_LAST);

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments only, so every
  // flop samples the pre-edge values of the other flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every signal written in a combinational block gets a default
  // first. Otherwise a missed branch would infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (req_from_crossbar) state_d = REQ;
      // Ack has priority over timeout, but both lead to RESP.
      REQ:  if (ack_from_slave || timeout_hit) state_d = RESP;
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Transaction / response registers and timeout counter
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q  <= '0;
      wdata_q <= '0;
      cmd_q   <= 1'b0;
      id_q    <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          // A req seen in IDLE is always a fresh transaction.
          if (req_from_crossbar) begin
            addr_q  <= addr_from_crossbar;
            wdata_q <= wdata_from_crossbar;
            cmd_q   <= cmd_from_crossbar;
            id_q    <= id_from_crossbar;
            cnt_q   <= '0;
          end
        end
        REQ: begin
          if (ack_from_slave) begin
            // A write returns zero read data.
            rdata_q <= cmd_q ? '0 : rdata_from_slave;
            err_q   <= 1'b0;
          end else if (timeout_hit) begin
            rdata_q <= '0;
            err_q   <= 1'b1;
          end else if (cnt_q != CNT_MAX) begin
            // Saturate rather than wrap. This matters only when the timeout
            // is disabled.
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Output logic: responses are masked outside RESP, and slave-side signals
  // are masked outside REQ. Reset forces IDLE, so all outputs drop to zero
  // at once.
  // ---------------------------------------------------------------------------
  always_comb begin
    ack_to_crossbar   = 1'b0;
    rdata_to_crossbar = '0;
    id_to_crossbar    = '0;
    err_to_crossbar   = 1'b0;
    req_to_slave      = 1'b0;
    addr_to_slave     = '0;
    wdata_to_slave    = '0;
    cmd_to_slave      = 1'b0;
    busy              = (state_q != IDLE);
    unique case (state_q)
      REQ: begin
        req_to_slave   = 1'b1;
        addr_to_slave  = addr_q;
        wdata_to_slave = wdata_q;
        cmd_to_slave   = cmd_q;
      end
      RESP: begin
        ack_to_crossbar   = 1'b1;
        rdata_to_crossbar = rdata_q;
        id_to_crossbar    = id_q;
        err_to_crossbar   = err_q;
      end
      default: ;
    endcase
  end

endmodule

// File: doc/slave_if.md
Name: slave_if

Overview:
- Slave-side end of the crossbar request/ack protocol: accepts one transaction from the crossbar, drives it to the attached slave, and returns ack/rdata to the crossbar.
- Registers each transaction, holds it stable toward the slave until the slave acks, and tags the response with the requesting master's ID.
- A timeout counter converts a hung slave into an error response so the crossbar arbitration never locks up.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- ID_W, 2, master ID width
- TIMEOUT, 255, max cycles waiting for slave ack; 0 disables the timeout

Ports:
- clk  input  1  clock, all logic on rising edge
- rst_n  input  1  asynchronous active-low reset
- req_from_crossbar  input  1  transaction request; held high by the crossbar until ack_to_crossbar
- addr_from_crossbar  input  ADDR_W  address
- wdata_from_crossbar  input  DATA_W  write data
- cmd_from_crossbar  input  1  1 = write, 0 = read
- id_from_crossbar  input  ID_W  requesting master ID
- ack_to_crossbar  output  1  one-cycle completion pulse
- rdata_to_crossbar  output  DATA_W  read data, valid only with ack
- id_to_crossbar  output  ID_W  ID of completed transaction, valid only with ack
- err_to_crossbar  output  1  timeout error, valid only with ack
- req_to_slave  output  1  request to slave
- addr_to_slave  output  ADDR_W  registered address
- wdata_to_slave  output  DATA_W  registered write data
- cmd_to_slave  output  1  registered command
- ack_from_slave  input  1  slave completion; may be combinational or delayed
- rdata_from_slave  input  DATA_W  slave read data, sampled with ack_from_slave
- busy  output  1  high in any state other than IDLE

Behaviour:
- Reset: asynchronous. State goes to IDLE and all outputs and internal registers go to 0 immediately. An in-flight transaction is dropped with no response.
- FSM states: IDLE, REQ, RESP.
- IDLE:
  - If req_from_crossbar=1, capture addr, wdata, cmd and id into registers, clear the timeout counter, and go to REQ.
  - ack_from_slave is ignored.
- REQ:
  - req_to_slave=1; addr/wdata/cmd_to_slave are driven from the registers and stay constant for the whole state.
  - If ack_from_slave=1: capture rdata_from_slave when cmd=0, capture 0 when cmd=1; set err=0; go to RESP.
  - Else if TIMEOUT!=0 and the counter equals TIMEOUT-1: capture rdata=0, set err=1, go to RESP.
  - Else increment the counter.
  - If ack and timeout occur in the same cycle, ack wins (err=0).
- RESP:
  - ack_to_crossbar=1 for exactly one cycle; rdata/id/err_to_crossbar come from the registers.
  - req_to_slave=0. Always returns to IDLE.
- Output masking:
  - Outside RESP, rdata_to_crossbar, id_to_crossbar and err_to_crossbar are 0.
  - Outside REQ, req_to_slave, addr_to_slave, wdata_to_slave and cmd_to_slave are 0.
- Crossbar rule: the crossbar drops req or presents a new transaction in the cycle after ack. A req that is high in IDLE is always a new transaction.
- Latency:
  - req sampled at edge T; req_to_slave=1 from T+1.
  - Slave ack sampled at edge T+k (k>=1); ack_to_crossbar=1 in cycle T+k+1.
  - Minimum request-to-ack is 2 cycles, with a 3-cycle period for back-to-back transactions.
- Timeout error: TIMEOUT cycles of REQ with no ack produce err.
- Counter: width is clog2(TIMEOUT+1), minimum 1 bit. It saturates and never wraps.
- Late acks: an ack_from_slave arriving in RESP or IDLE (for example after a timeout) is ignored.

Test Plan:
- Write: addr=0x0000_0040, wdata=0xCAFE_F00D, cmd=1, id=2; slave acks 2 cycles after req_to_slave -> addr/wdata/cmd_to_slave stable throughout REQ; ack_to_crossbar for one cycle with id=2, err=0, rdata=0.
- Read: cmd=0, addr=0x10; slave acks combinationally with rdata=0xDEAD_BEEF -> ack_to_crossbar exactly 2 cycles after req sampled, rdata_to_crossbar=0xDEAD_BEEF, rdata=0 in all other cycles.
- Timeout: TIMEOUT=4, slave never acks -> req_to_slave high for 4 cycles, then ack with err=1, rdata=0; a later slave ack is ignored and produces no second response.
- Ack/timeout collision: TIMEOUT=4, slave ack on the 4th REQ cycle with rdata=0x1234 -> err=0, rdata=0x1234.
- Back-to-back: req held high with a new addr/id presented the cycle after ack -> second transaction captured in IDLE, no duplicate; ack pulses 3 cycles apart with a zero-latency slave.
- Reset: assert rst_n=0 mid-REQ -> all outputs 0 immediately, busy=0, no ack after release; the next req completes normally.
